aes_lite_key_sched: RTL
=======================

// Module: aes_lite_key_sched
// PURPOSE
//   Upstream key-schedule stage for the 8-bit AES-lite round controller.
//   Accepts an 8-bit cipher key and expands it into NUM_ROUNDS+1 round keys:
//   one key per cycle, stored in an internal table.
//   The round controller reads round keys by index through a 1-cycle-latency read port.
//   A new load restarts expansion at any time.
// PARAMETERS
//   NUM_ROUNDS  10     number of round keys after rk[0]; legal range 1..14
//   RCON_INIT   8'h01  round constant used for rk[1]
// PORTS
//   clk         in   1  clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   key_load    in   1  pulse: sample key_in and start expansion
//   key_in      in   8  cipher key, becomes rk[0]
//   busy        out  1  1 while expansion is in progress
//   keys_ready  out  1  1 when rk[0..NUM_ROUNDS] are all valid
//   round_cnt   out  4  index of the key being generated (debug)
//   rd_en       in   1  read request
//   rd_idx      in   4  round-key index to read
//   rd_valid    out  1  read response strobe, 1 cycle after rd_en
//   rd_data     out  8  round key, valid when rd_valid=1
//   rd_err      out  1  read rejected, qualifies rd_valid
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; busy=0, keys_ready=0, round_cnt=0.
//     rd_valid=0, rd_data=0, rd_err=0. Key table cleared to 0. rcon register=RCON_INIT.
//   FSM states: IDLE -> EXPAND -> READY.
//     - key_load in any state at edge E0: rk[0]<=key_in, rcon<=RCON_INIT,
//       round_cnt<=1, state<=EXPAND. keys_ready drops after E0.
//     - EXPAND at each edge: rk[round_cnt]<=F(rk[round_cnt-1], rcon).
//       Then rcon<=xtime(rcon) and round_cnt++.
//       When round_cnt==NUM_ROUNDS: state<=READY, round_cnt<=0.
//     - READY: holds until the next key_load. IDLE: waits for key_load.
//   Outputs and latency:
//     - busy = (state==EXPAND). keys_ready = (state==READY).
//     - keys_ready rises after edge E_NUM_ROUNDS, i.e. NUM_ROUNDS cycles after E0.
//   Key function F(k, rc):
//     - t = {k[6:0],k[7]} (rotate left 1).
//     - u = {S(t[7:4]), S(t[3:0])}.
//     - result = u ^ rc.
//     - S (4-bit): 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//     - xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).
//     - All arithmetic is 8-bit with no carries.
//   Read port:
//     - rd_en sampled at edge Ek; rd_valid=1 for exactly one cycle after Ek.
//     - Good read (keys_ready=1 and rd_idx<=NUM_ROUNDS): rd_data=rk[rd_idx], rd_err=0.
//     - Bad read (keys_ready=0, or rd_idx>NUM_ROUNDS): rd_data=0, rd_err=1.
//     - Back-to-back rd_en is supported, one response per cycle.
//     - When rd_valid=0, rd_data=0 and rd_err=0.
//   Simultaneous events:
//     - key_load plus rd_en at the same edge: the read is evaluated against the
//       pre-edge state. In READY it returns the old key; the old key is still stored.
//     - key_load during EXPAND aborts the current expansion and restarts from the new key_in.
//   Reset mid-expansion clears everything; no partial keys_ready.
// TESTING
//   1. Reset -> busy=0, keys_ready=0, rd_en idx0 -> rd_valid=1, rd_err=1, rd_data=00.
//   2. Load 8'h00 -> rk1=8'hCD, rk2=8'hEA; keys_ready exactly 10 cycles after load edge.
//   3. Load 8'hFF -> rk0=8'hFF, rk1=8'h23; idx 11 read -> rd_err=1, rd_data=00.
//   4. Reload 8'hFF mid-EXPAND (round_cnt=5) after load 00 -> rk1=8'h23, ready 10 cycles later.
//   5. Burst rd_en idx 0..10 back-to-back -> 11 consecutive rd_valid, rk0..rk10, matching model.
//   6. Assert rst during EXPAND -> all outputs 0 immediately, FSM in IDLE, no stray rd_valid.

Source files
------------

// File: rtl/aes_lite_key_sched.sv
// AES-lite key schedule: expands an 8-bit cipher key into NUM_ROUNDS+1 round keys,
// one per cycle, and serves them through a registered 1-cycle-latency read port.
module aes_lite_key_sched #(
    parameter int          NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_load,
    input  logic [7:0] key_in,
    output logic       busy,
    output logic       keys_ready,
    output logic [3:0] round_cnt,
    input  logic       rd_en,
    input  logic [3:0] rd_idx,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_err
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t      state_q;
    logic        busy_q;
    logic        ready_q;
    logic [3:0]  roundCnt_q;
    logic [7:0]  rcon_q;
    logic [7:0]  keyTable_q [0:15];
    logic        rdValid_q;
    logic [7:0]  rdData_q;
    logic        rdErr_q;

    logic [7:0]  prevKey_d;
    logic [7:0]  newKey_d;
    logic [7:0]  rconNext_d;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [7:0] keyFunc(input logic [7:0] k, input logic [7:0] rc);
        logic [7:0] t;
        t = {k[6:0], k[7]};
        return {sbox4(t[7:4]), sbox4(t[3:0])} ^ rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    always_comb begin
        prevKey_d  = keyTable_q[roundCnt_q - 4'd1];
        newKey_d   = keyFunc(prevKey_d, rcon_q);
        rconNext_d = xtime(rcon_q);
    end

    // key_load wins in every state, so a load during EXPAND simply restarts from rk[0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            roundCnt_q <= 4'd0;
            rcon_q     <= RCON_INIT;
            keyTable_q <= '{default: 8'h00};
        end else if (key_load) begin
            keyTable_q[0] <= key_in;
            rcon_q        <= RCON_INIT;
            roundCnt_q    <= 4'd1;
            state_q       <= EXPAND;
            busy_q        <= 1'b1;
            ready_q       <= 1'b0;
        end else begin
            case (state_q)
                EXPAND: begin
                    keyTable_q[roundCnt_q] <= newKey_d;
                    rcon_q                 <= rconNext_d;
                    if (roundCnt_q == 4'(NUM_ROUNDS)) begin
                        state_q    <= READY;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                        roundCnt_q <= 4'd0;
                    end else begin
                        roundCnt_q <= roundCnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    // Reads see pre-edge table contents, so a simultaneous key_load still returns the old key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdValid_q <= 1'b0;
            rdData_q  <= 8'h00;
            rdErr_q   <= 1'b0;
        end else begin
            rdValid_q <= rd_en;
            if (rd_en && ready_q && (rd_idx <= 4'(NUM_ROUNDS))) begin
                rdData_q <= keyTable_q[rd_idx];
                rdErr_q  <= 1'b0;
            end else begin
                rdData_q <= 8'h00;
                rdErr_q  <= rd_en;
            end
        end
    end

    assign busy       = busy_q;
    assign keys_ready = ready_q;
    assign round_cnt  = roundCnt_q;
    assign rd_valid   = rdValid_q;
    assign rd_data    = rdData_q;
    assign rd_err     = rdErr_q;

endmodule
